// File: rtl/audio_dac.sv
// rtl/audio_dac.sv - mixer sample capture, one-pole IIR smoother and sigma-delta ladder DAC
// Optional macro AUDIO_DAC_DITHER_EN adds LFSR dither to the sigma-delta stage.
module audio_dac #(
    parameter int IN_W       = 6,
    parameter int OUT_W      = 4,
    parameter int FRAC_W     = 8,
    parameter int FILT_SHIFT = 3
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_ena4,
    input  logic [IN_W-1:0]          i_audio,
    input  logic                     i_mute,
    output logic [OUT_W-1:0]         o_audio,
    output logic [IN_W+FRAC_W-1:0]   o_level
);
    localparam int ACC_W = IN_W + FRAC_W;
    localparam int D_W   = ACC_W + 1;
    localparam int LO_W  = ACC_W - OUT_W;

    logic [IN_W-1:0]        s_in_q;
    logic                   ena_d_q;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [LO_W-1:0]        sd_frac_q, sd_frac_d;
    logic [OUT_W-1:0]       audio_q, audio_d;
    logic [OUT_W-1:0]       acc_hi;
    logic                   carry;
    logic signed [D_W-1:0]  diff, step;

    // Round the step away from zero on small positive errors so acc lands exactly on target
    always_comb begin
        diff = $signed({1'b0, s_in_q, {FRAC_W{1'b0}}}) - $signed({1'b0, acc_q});
        step = diff >>> FILT_SHIFT;
        if (step == '0 && !diff[D_W-1] && diff != '0)
            step = {{(D_W-1){1'b0}}, 1'b1};
        acc_d = ena_d_q ? acc_q + step[ACC_W-1:0] : acc_q;
    end

`ifdef AUDIO_DAC_DITHER_EN
    logic [15:0]              lfsr_q;
    logic signed [LO_W+2:0]   dsum_raw, dsum;

    // Carried one bit wider than the nominal 12 so a full-scale fraction plus dither cannot wrap
    always_comb begin
        dsum_raw = $signed({3'b000, sd_frac_q}) + $signed({3'b000, acc_q[LO_W-1:0]})
                 + $signed({{(LO_W-1){1'b0}}, lfsr_q[3:0]}) - $signed((LO_W+3)'(8));
        dsum      = dsum_raw[LO_W+2] ? '0 : dsum_raw;
        carry     = dsum >= $signed({3'b001, {LO_W{1'b0}}});
        sd_frac_d = dsum[LO_W-1:0];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            lfsr_q <= 16'hACE1;
        else
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
`else
    logic [LO_W:0] sum;

    always_comb begin
        sum       = {1'b0, sd_frac_q} + {1'b0, acc_q[LO_W-1:0]};
        carry     = sum[LO_W];
        sd_frac_d = sum[LO_W-1:0];
    end
`endif

    // Top code already at full scale cannot take the carry without wrapping to 0
    always_comb begin
        acc_hi  = acc_q[ACC_W-1 -: OUT_W];
        audio_d = (&acc_hi) ? acc_hi : acc_hi + {{(OUT_W-1){1'b0}}, carry};
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s_in_q    <= '0;
            ena_d_q   <= 1'b0;
            acc_q     <= '0;
            sd_frac_q <= '0;
            audio_q   <= '0;
        end else begin
            if (i_ena4)
                s_in_q <= i_mute ? '0 : i_audio;
            ena_d_q   <= i_ena4;
            acc_q     <= acc_d;
            sd_frac_q <= sd_frac_d;
            audio_q   <= audio_d;
        end
    end

    assign o_audio = audio_q;
    assign o_level = acc_q;
endmodule

// File: tb/tb_audio_dac.sv
// tb/tb_audio_dac.sv - randomized and directed checks of audio_dac against an arithmetic filter model
module tb_audio_dac;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena4 = 1'b0;
    logic [5:0]  audio = '0;
    logic        mute = 1'b0;
    logic [3:0]  o_audio;
    logic [13:0] o_level;

    int passed = 0;
    int total  = 0;

    int m_acc = 0;
    int m_s   = 0;
    bit m_pend = 1'b0;

    audio_dac dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_ena4  (ena4),
        .i_audio (audio),
        .i_mute  (mute),
        .o_audio (o_audio),
        .o_level (o_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One filter step toward target s: move 1/8 of the error, rounded toward -inf, at least 1 upward
    function automatic int filt(input int acc, input int s);
        int d, st;
        d = s * 256 - acc;
        if (d >= 0) begin
            st = d / 8;
            if (st == 0 && d > 0) st = 1;
        end else begin
            st = -((-d + 7) / 8);
        end
        return acc + st;
    endfunction

    task automatic model_reset();
        m_acc  = 0;
        m_s    = 0;
        m_pend = 1'b0;
    endtask

    task automatic clk1(input bit ena, input bit check_level);
        ena4 = ena;
        @(posedge clk);
        if (m_pend) m_acc = filt(m_acc, m_s);
        if (ena) m_s = mute ? 0 : int'(audio);
        m_pend = ena;
        #1;
        if (check_level) chk("level", int'(o_level), m_acc);
    endtask

    task automatic strobes(input int n, input bit check_level);
        repeat (n) begin
            clk1(1'b1, check_level);
            repeat (3) clk1(1'b0, check_level);
        end
    endtask

    // 1024 clocks at constant level: carries add up to exactly the 10 fraction bits
    task automatic window(input string tag, output int nines);
        int sum, exp;
        sum = 0;
        nines = 0;
        repeat (1024) begin
            clk1(1'b0, 1'b0);
            sum += int'(o_audio);
            if (o_audio == 4'd9) nines++;
        end
        exp = ((m_acc >> 10) == 15) ? 15 * 1024 : (m_acc >> 10) * 1024 + (m_acc % 1024);
`ifdef AUDIO_DAC_DITHER_EN
        chk({tag, "_sum_near"}, int'(sum >= exp - 4 && sum <= exp + 4), 1);
`else
        chk({tag, "_sum"}, sum, exp);
`endif
    endtask

    initial begin
        int nines, prev, errs;
        bit stuck;

        #2;
        chk("rst_audio", int'(o_audio), 0);
        chk("rst_level", int'(o_level), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();

        // Async reset in the middle of a full-scale ramp with the strobe toggling
        audio = 6'd63;
        strobes(5, 1'b1);
        clk1(1'b1, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_audio", int'(o_audio), 0);
        chk("async_rst_level", int'(o_level), 0);
        repeat (3) begin
            @(negedge clk) ena4 = ~ena4;
        end
        @(posedge clk);
        #1;
        chk("held_rst_level", int'(o_level), 0);
        rst = 1'b0;
        model_reset();

        clk1(1'b1, 1'b0);
        chk("lat_edge1", int'(o_level), 0);
        clk1(1'b0, 1'b0);
        chk("lat_edge2", int'(o_level), 2016);
        model_reset();
        rst = 1'b1;
        #1 rst = 1'b0;

        // Mid-scale: no fraction, so no carries at all
        audio = 6'd32;
        strobes(300, 1'b1);
        chk("lvl32", int'(o_level), 14'h2000);
        errs = 0;
        repeat (64) begin
            clk1(1'b0, 1'b0);
            if (o_audio != 4'd8) errs++;
        end
`ifndef AUDIO_DAC_DITHER_EN
        chk("out32_const", errs, 0);
`endif
        window("w32", nines);

        audio = 6'd33;
        strobes(300, 1'b1);
        chk("lvl33", int'(o_level), 14'h2100);
        window("w33", nines);
`ifndef AUDIO_DAC_DITHER_EN
        chk("w33_nines", nines, 256);
`endif

        audio = 6'd63;
        strobes(300, 1'b1);
        chk("lvl63", int'(o_level), 16128);
        errs = 0;
        repeat (256) begin
            clk1(1'b0, 1'b0);
            if (o_audio != 4'd15) errs++;
        end
        chk("out63_sat", errs, 0);
        window("w63", nines);

        // Mute: monotonic descent to exactly 0, then recovery
        mute = 1'b1;
        prev = int'(o_level);
        errs = 0;
        repeat (400) begin
            clk1(1'b1, 1'b1);
            if (int'(o_level) > prev) errs++;
            prev = int'(o_level);
            repeat (3) begin
                clk1(1'b0, 1'b1);
                if (int'(o_level) > prev) errs++;
                prev = int'(o_level);
            end
        end
        chk("mute_mono", errs, 0);
        chk("mute_zero", int'(o_level), 0);
        errs = 0;
        repeat (64) begin
            clk1(1'b0, 1'b0);
            if (o_audio != 4'd0) errs++;
        end
        chk("mute_out0", errs, 0);
        mute = 1'b0;
        strobes(3, 1'b1);
        chk("unmute_rise", int'(o_level > 0), 1);

        // Random levels, mid-sample mute toggles, and stretches with the strobe stuck high
        errs = 0;
        stuck = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 150 == 0) audio = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 99) == 0) mute = ~mute;
            if (i % 500 == 0) stuck = ($urandom_range(0, 3) == 0);
            clk1(stuck || (i % 4 == 0), 1'b1);
            if (int'(o_level) > 16128) errs++;
        end
        chk("rand_range", errs, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
